// File: rtl/dna_port_reader.sv
// dna_port_reader
//
// Reads the device DNA out of a DNA_PORTE2 primitive and presents it as a
// parallel word. One LOAD cycle (READ=1) makes the primitive copy its DNA
// into its shift register. DNA_WIDTH SHIFT cycles then clock the bits out
// LSB-first. DOUT is looped straight back into DIN, so after a full pass the
// primitive's register holds its original contents again. With VERIFY=1 a
// second full pass re-reads the recirculated value and flags any difference
// from the first capture.
//
// Ports
//   CLK        clock shared with the DNA_PORTE2 primitive
//   RST        synchronous, active-high reset
//   START      one-cycle read request, honoured only in IDLE or DONE
//   BUSY       high while a read is in progress
//   DNA_VALID  DNA_VALUE holds a completed read
//   DNA_ERROR  the verify pass disagreed with the capture (when DNA_VALID=1)
//   DNA_VALUE  captured DNA, bit 0 is the first bit shifted out
//   DNA_READ   to primitive READ (registered)
//   DNA_SHIFT  to primitive SHIFT (registered)
//   DNA_DIN    to primitive DIN, wired to DNA_DOUT
//   DNA_DOUT   from primitive DOUT
module dna_port_reader #(
  parameter int DNA_WIDTH  = 96,
  parameter int VERIFY     = 1,
  parameter int AUTO_START = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 BUSY,
  output logic                 DNA_VALID,
  output logic                 DNA_ERROR,
  output logic [DNA_WIDTH-1:0] DNA_VALUE,
  output logic                 DNA_READ,
  output logic                 DNA_SHIFT,
  output logic                 DNA_DIN,
  input  logic                 DNA_DOUT
);

  localparam int CW = (DNA_WIDTH > 1) ? $clog2(DNA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DNA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CAPTURE,
    S_VERIFY,
    S_DONE
  } state_t;

  state_t               state_reg, state_next;
  logic [DNA_WIDTH-1:0] cap_reg, cap_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic                 mismatch_reg, mismatch_next;
  // Armed by reset when AUTO_START=1; consumed by the first IDLE cycle.
  logic                 auto_reg, auto_next;

  logic                 busy_reg, valid_reg, error_reg, read_reg, shift_reg;
  logic [DNA_WIDTH-1:0] value_reg;

  // Recirculation keeps the primitive's contents intact across passes.
  assign DNA_DIN   = DNA_DOUT;
  assign BUSY      = busy_reg;
  assign DNA_VALID = valid_reg;
  assign DNA_ERROR = error_reg;
  assign DNA_VALUE = value_reg;
  assign DNA_READ  = read_reg;
  assign DNA_SHIFT = shift_reg;

  always_comb begin
    state_next    = state_reg;
    cap_next      = cap_reg;
    cnt_next      = cnt_reg;
    mismatch_next = mismatch_reg;
    auto_next     = auto_reg;
    case (state_reg)
      S_IDLE: begin
        if (START || auto_reg) begin
          state_next    = S_LOAD;
          auto_next     = 1'b0;
          cap_next      = '0;
          mismatch_next = 1'b0;
        end
      end
      S_LOAD: begin
        state_next = S_CAPTURE;
        cnt_next   = '0;
      end
      S_CAPTURE: begin
        // DOUT already presents bit k during cycle k; no extra sampling stage.
        cap_next = {DNA_DOUT, cap_reg[DNA_WIDTH-1:1]};
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_IDX) begin
          cnt_next   = '0;
          state_next = (VERIFY != 0) ? S_VERIFY : S_DONE;
        end
      end
      S_VERIFY: begin
        if (DNA_DOUT != cap_reg[cnt_reg]) begin
          mismatch_next = 1'b1;
        end
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_IDX) begin
          cnt_next   = '0;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (START) begin
          state_next    = S_LOAD;
          cap_next      = '0;
          mismatch_next = 1'b0;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= S_IDLE;
      cap_reg      <= '0;
      cnt_reg      <= '0;
      mismatch_reg <= 1'b0;
      auto_reg     <= (AUTO_START != 0);
      busy_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      error_reg    <= 1'b0;
      value_reg    <= '0;
      read_reg     <= 1'b0;
      shift_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cap_reg      <= cap_next;
      cnt_reg      <= cnt_next;
      mismatch_reg <= mismatch_next;
      auto_reg     <= auto_next;
      // Controls are decoded from the next state so they are true flops
      // that line up exactly with the state they belong to.
      read_reg     <= (state_next == S_LOAD);
      shift_reg    <= (state_next == S_CAPTURE) || (state_next == S_VERIFY);
      busy_reg     <= (state_next == S_LOAD) || (state_next == S_CAPTURE) ||
                      (state_next == S_VERIFY);
      if (state_next == S_LOAD) begin
        valid_reg <= 1'b0;
        error_reg <= 1'b0;
      end else if ((state_next == S_DONE) && (state_reg != S_DONE)) begin
        // Publish only complete results; cap_next/mismatch_next include
        // the final bit of the pass that is ending on this edge.
        value_reg <= cap_next;
        error_reg <= mismatch_next;
        valid_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dna_port_reader.sv
// Testbench for dna_port_reader.
// Two instances share one clock: "a" reads with a verify pass and starts by
// itself after reset, "b" does a single pass and waits for START. Each has a
// behavioural DNA_PORTE2 model (load on READ, shift right on SHIFT, DOUT is
// the register LSB). Instance a's model can flip DOUT at one verify index.
module tb_dna_port_reader;

  localparam int W = 96;
  localparam logic [W-1:0] SIM_A  = 96'h0123_4567_89AB_CDEF_FEDC_BA98;
  localparam logic [W-1:0] SIM_FD = 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFD;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         a_rst, a_start, a_busy, a_valid, a_err, a_read, a_shift, a_din, a_dout;
  logic [W-1:0] a_value;
  logic         b_rst, b_start, b_busy, b_valid, b_err, b_read, b_shift, b_din, b_dout;
  logic [W-1:0] b_value;

  dna_port_reader #(.DNA_WIDTH(W), .VERIFY(1), .AUTO_START(1)) dut_a (
    .CLK(clk), .RST(a_rst), .START(a_start), .BUSY(a_busy), .DNA_VALID(a_valid),
    .DNA_ERROR(a_err), .DNA_VALUE(a_value), .DNA_READ(a_read), .DNA_SHIFT(a_shift),
    .DNA_DIN(a_din), .DNA_DOUT(a_dout)
  );

  dna_port_reader #(.DNA_WIDTH(W), .VERIFY(0), .AUTO_START(0)) dut_b (
    .CLK(clk), .RST(b_rst), .START(b_start), .BUSY(b_busy), .DNA_VALID(b_valid),
    .DNA_ERROR(b_err), .DNA_VALUE(b_value), .DNA_READ(b_read), .DNA_SHIFT(b_shift),
    .DNA_DIN(b_din), .DNA_DOUT(b_dout)
  );

  // Primitive models.
  logic [W-1:0] a_sim, b_sim;
  logic [W-1:0] a_sr = '0;
  logic [W-1:0] b_sr = '0;
  int           a_shcnt = 0;
  int           a_inj_idx;
  logic         a_inject;

  always @(posedge clk) begin
    if (a_read) begin
      a_sr    <= a_sim;
      a_shcnt <= 0;
    end else if (a_shift) begin
      a_sr    <= {a_din, a_sr[W-1:1]};
      a_shcnt <= a_shcnt + 1;
    end
  end

  always @(posedge clk) begin
    if (b_read) b_sr <= b_sim;
    else if (b_shift) b_sr <= {b_din, b_sr[W-1:1]};
  end

  always_comb a_inject = a_shift && (a_inj_idx >= 0) && (a_shcnt == W + a_inj_idx);
  assign a_dout = a_sr[0] ^ a_inject;
  assign b_dout = b_sr[0];

  int vectors = 0;
  int miscompares = 0;

  // Runs one read on the selected instance, one cycle per iteration sampled
  // at the falling edge. n counts edges after the START-accepting edge when
  // the caller enters right after that edge. pulse indices raise START during
  // that SHIFT cycle. Returns observations only; the tests judge them.
  task automatic drive(input bit sel, input int limit, input int p0, input int p1,
                       output int n_valid, output int reads, output int shifts,
                       output int span, output int overlap, output int busy_bad,
                       output int din_bad, output logic [W-1:0] trace);
    int   n, first_sh, last_sh;
    logic rd, sh, vl, bs, di, dq;
    n = 0; n_valid = -1; reads = 0; shifts = 0; overlap = 0; busy_bad = 0;
    din_bad = 0; trace = '0; first_sh = -1; last_sh = -2;
    while (n <= limit) begin
      if (sel) b_start = 1'b0; else a_start = 1'b0;
      rd = sel ? b_read  : a_read;
      sh = sel ? b_shift : a_shift;
      vl = sel ? b_valid : a_valid;
      bs = sel ? b_busy  : a_busy;
      di = sel ? b_din   : a_din;
      dq = sel ? b_dout  : a_dout;
      if (rd) reads++;
      if (rd && sh) overlap++;
      if (di !== dq) din_bad++;
      if (vl === bs) busy_bad++;
      if (sh) begin
        if (shifts < W) trace[shifts] = dq;
        if (first_sh < 0) first_sh = n;
        last_sh = n;
        if (shifts == p0 || shifts == p1) begin
          if (sel) b_start = 1'b1; else a_start = 1'b1;
        end
        shifts++;
      end
      if (vl === 1'b1) begin
        n_valid = n;
        break;
      end
      @(negedge clk);
      n++;
    end
    if (sel) b_start = 1'b0; else a_start = 1'b0;
    span = last_sh - first_sh + 1;
  endtask

  task automatic test_reset;
    vectors++;
    if ({a_busy, a_valid, a_err, a_read, a_shift} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_a_ctrl got %b want 00000", {a_busy, a_valid, a_err, a_read, a_shift});
    end
    vectors++;
    if (a_value !== '0) begin
      miscompares++;
      $display("FAIL reset_a_value got %h want 0", a_value);
    end
    vectors++;
    if ({b_busy, b_valid, b_err, b_read, b_shift} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_b_ctrl got %b want 00000", {b_busy, b_valid, b_err, b_read, b_shift});
    end
    vectors++;
    if (b_value !== '0) begin
      miscompares++;
      $display("FAIL reset_b_value got %h want 0", b_value);
    end
  endtask

  task automatic test_auto_verify;
    int n, rd, sh, sp, ov, bb, db;
    logic [W-1:0] tr;
    a_sim = SIM_A;
    a_rst = 1'b0;
    @(negedge clk);
    drive(1'b0, 400, -1, -1, n, rd, sh, sp, ov, bb, db, tr);
    vectors++;
    if (n !== 2 * W + 1) begin
      miscompares++;
      $display("FAIL auto_latency got %0d want %0d", n, 2 * W + 1);
    end
    vectors++;
    if (a_value !== SIM_A || a_err !== 1'b0) begin
      miscompares++;
      $display("FAIL auto_value got %h err %b want %h err 0", a_value, a_err, SIM_A);
    end
    vectors++;
    if (rd !== 1 || sh !== 2 * W || sp !== 2 * W || ov !== 0) begin
      miscompares++;
      $display("FAIL auto_controls reads %0d shifts %0d span %0d overlap %0d want 1 192 192 0",
               rd, sh, sp, ov);
    end
    vectors++;
    if (tr !== SIM_A || bb !== 0 || db !== 0) begin
      miscompares++;
      $display("FAIL auto_trace got %h busy_bad %0d din_bad %0d want %h 0 0", tr, bb, db, SIM_A);
    end
  endtask

  task automatic test_single_pass;
    int n, rd, sh, sp, ov, bb, db;
    logic [W-1:0] tr, v;
    b_rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({b_busy, b_valid, b_read, b_shift} !== 4'b0) begin
        miscompares++;
        $display("FAIL idle_no_auto got %b want 0000", {b_busy, b_valid, b_read, b_shift});
      end
    end
    for (int i = 0; i < 3; i++) begin
      v = (i == 0) ? SIM_A : {$urandom, $urandom, $urandom};
      b_sim = v;
      b_start = 1'b1;
      @(negedge clk);
      drive(1'b1, 300, -1, -1, n, rd, sh, sp, ov, bb, db, tr);
      vectors++;
      if (n !== W + 1) begin
        miscompares++;
        $display("FAIL single_latency[%0d] got %0d want %0d", i, n, W + 1);
      end
      vectors++;
      if (b_value !== v || b_err !== 1'b0) begin
        miscompares++;
        $display("FAIL single_value[%0d] got %h err %b want %h err 0", i, b_value, b_err, v);
      end
      vectors++;
      if (tr !== v) begin
        miscompares++;
        $display("FAIL single_trace[%0d] got %h want %h", i, tr, v);
      end
      vectors++;
      if (rd !== 1 || sh !== W || sp !== W || ov !== 0 || bb !== 0 || db !== 0) begin
        miscompares++;
        $display("FAIL single_controls[%0d] r %0d s %0d sp %0d ov %0d bb %0d db %0d want 1 96 96 0 0 0",
                 i, rd, sh, sp, ov, bb, db);
      end
    end
  endtask

  task automatic test_verify_error;
    int n, rd, sh, sp, ov, bb, db, idx;
    logic [W-1:0] tr, v;
    logic exp_err;
    for (int i = 0; i < 4; i++) begin
      v   = (i == 0) ? SIM_A : {$urandom, $urandom, $urandom};
      idx = (i == 0) ? 40 : ((i % 2 == 1) ? -1 : int'($urandom_range(0, W - 1)));
      exp_err = (idx >= 0);
      a_sim = v;
      a_inj_idx = idx;
      a_start = 1'b1;
      @(negedge clk);
      drive(1'b0, 400, -1, -1, n, rd, sh, sp, ov, bb, db, tr);
      a_inj_idx = -1;
      vectors++;
      if (n !== 2 * W + 1) begin
        miscompares++;
        $display("FAIL verify_latency[%0d] got %0d want %0d", i, n, 2 * W + 1);
      end
      vectors++;
      if (a_value !== v) begin
        miscompares++;
        $display("FAIL verify_value[%0d] got %h want %h", i, a_value, v);
      end
      vectors++;
      if (a_err !== exp_err) begin
        miscompares++;
        $display("FAIL verify_error[%0d] inj %0d got %b want %b", i, idx, a_err, exp_err);
      end
    end
  endtask

  task automatic test_start_ignored;
    int n, rd, sh, sp, ov, bb, db;
    logic [W-1:0] tr, v;
    v = {$urandom, $urandom, $urandom};
    a_sim = v;
    a_start = 1'b1;
    @(negedge clk);
    drive(1'b0, 400, 50, W + 20, n, rd, sh, sp, ov, bb, db, tr);
    vectors++;
    if (n !== 2 * W + 1 || rd !== 1 || sh !== 2 * W) begin
      miscompares++;
      $display("FAIL ignored_start lat %0d reads %0d shifts %0d want 193 1 192", n, rd, sh);
    end
    vectors++;
    if (a_value !== v || a_err !== 1'b0) begin
      miscompares++;
      $display("FAIL ignored_value got %h err %b want %h err 0", a_value, a_err, v);
    end
    // The ignored pulses must not have queued a new read.
    repeat (3) @(negedge clk);
    vectors++;
    if ({a_valid, a_busy, a_read} !== 3'b100) begin
      miscompares++;
      $display("FAIL ignored_no_queue got %b want 100", {a_valid, a_busy, a_read});
    end
  endtask

  task automatic test_reset_mid;
    int n, rd, sh, sp, ov, bb, db, cnt, guard;
    logic [W-1:0] tr, v;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    cnt = 0;
    guard = 0;
    while (guard < 200) begin
      if (b_shift) cnt++;
      if (cnt == 31) break;
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (cnt !== 31) begin
      miscompares++;
      $display("FAIL midrst_reach got %0d shifts want 31", cnt);
    end
    b_rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if ({b_busy, b_valid, b_err, b_read, b_shift} !== 5'b0 || b_value !== '0) begin
        miscompares++;
        $display("FAIL midrst_in_reset ctrl %b value %h want 0",
                 {b_busy, b_valid, b_err, b_read, b_shift}, b_value);
      end
    end
    b_rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({b_busy, b_valid, b_err, b_read, b_shift} !== 5'b0) begin
        miscompares++;
        $display("FAIL midrst_after ctrl %b want 00000", {b_busy, b_valid, b_err, b_read, b_shift});
      end
    end
    v = {$urandom, $urandom, $urandom};
    b_sim = v;
    b_start = 1'b1;
    @(negedge clk);
    drive(1'b1, 300, -1, -1, n, rd, sh, sp, ov, bb, db, tr);
    vectors++;
    if (n !== W + 1 || b_value !== v || rd !== 1) begin
      miscompares++;
      $display("FAIL midrst_reread lat %0d value %h reads %0d want 97 %h 1", n, b_value, rd, v);
    end
  endtask

  task automatic test_back_to_back;
    int n, rd, sh, sp, ov, bb, db;
    logic [W-1:0] tr;
    b_sim = SIM_FD;
    vectors++;
    if (b_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_precond valid got %b want 1", b_valid);
    end
    b_start = 1'b1;
    @(negedge clk);
    vectors++;
    if ({b_valid, b_busy, b_read} !== 3'b011) begin
      miscompares++;
      $display("FAIL b2b_first_pulse valid/busy/read got %b want 011", {b_valid, b_busy, b_read});
    end
    @(negedge clk);
    drive(1'b1, 300, -1, -1, n, rd, sh, sp, ov, bb, db, tr);
    vectors++;
    if (n !== W || rd !== 0 || sh !== W) begin
      miscompares++;
      $display("FAIL b2b_second_ignored lat %0d extra_reads %0d shifts %0d want 96 0 96", n, rd, sh);
    end
    vectors++;
    if (b_value !== SIM_FD) begin
      miscompares++;
      $display("FAIL b2b_value got %h want %h", b_value, SIM_FD);
    end
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_start = 1'b0; b_start = 1'b0;
    a_inj_idx = -1;
    a_sim = '0; b_sim = '0;
    repeat (3) @(negedge clk);
    test_reset;
    test_auto_verify;
    test_single_pass;
    test_verify_error;
    test_start_ignored;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dna_port_reader.md
# dna_port_reader

Controller that reads the 96-bit device DNA out of the DNA_PORTE2 primitive and presents it as a parallel word. It drives the primitive's READ/SHIFT/DIN pins, deserialises DOUT LSB-first, and recirculates DOUT into DIN so the primitive's shift register ends each pass holding its original contents. An optional second pass re-reads the value and flags a mismatch. It sits between the DNA primitive and the device-identification registers, on the same clock as the primitive.

## Interface
- DNA_WIDTH, 96, number of DNA bits read and presented.
- VERIFY, 1, when 1 perform a second compare pass after capture; when 0 finish after one pass.
- AUTO_START, 1, when 1 start a read automatically on the first cycle after RST deasserts.

- CLK  input  1  clock for this block and the DNA_PORTE2 primitive.
- RST  input  1  synchronous, active-high reset.
- START  input  1  single-cycle request to (re)read the DNA; sampled only in IDLE or DONE.
- BUSY  output  1  high from the cycle after an accepted start until the result is posted.
- DNA_VALID  output  1  high while DNA_VALUE holds a completed read; held until the next accepted start or RST.
- DNA_ERROR  output  1  verify-pass mismatch; meaningful only while DNA_VALID=1.
- DNA_VALUE  output  DNA_WIDTH  captured DNA; bit k is the k-th bit shifted out (bit 0 first).
- DNA_READ  output  1  to primitive READ; registered.
- DNA_SHIFT  output  1  to primitive SHIFT; registered.
- DNA_DIN  output  1  to primitive DIN; combinationally equal to DNA_DOUT.
- DNA_DOUT  input  1  from primitive DOUT.

## Operation
- States: IDLE, LOAD, CAPTURE, VERIFY, DONE.
- IDLE: all primitive controls low. Go to LOAD on START=1, or on the first post-reset cycle when AUTO_START=1.
- LOAD (1 cycle): DNA_READ=1, DNA_SHIFT=0. The primitive loads its DNA at the end of this cycle, and DOUT shows bit 0.
- CAPTURE (DNA_WIDTH cycles, index k=0..DNA_WIDTH-1): DNA_READ=0, DNA_SHIFT=1.
  - In cycle k, DNA_DOUT carries bit k.
  - At the end of the cycle the block shifts it in: cap <= {DNA_DOUT, cap[DNA_WIDTH-1:1]}.
  - The bit counter is $clog2(DNA_WIDTH) wide and clears on entry.
  - After the last cycle, go to VERIFY if VERIFY=1, else DONE.
- VERIFY (DNA_WIDTH cycles, index k): DNA_SHIFT=1, no READ.
  - The recirculated register presents bit k again in cycle k.
  - Any cycle with DNA_DOUT != cap[k] sets a sticky mismatch flag.
  - Go to DONE after the last cycle.
- DONE: DNA_VALUE <= cap, DNA_ERROR <= mismatch, DNA_VALID=1, controls low.
  - START=1 in DONE clears DNA_VALID and DNA_ERROR on the next edge and goes to LOAD.
- START while BUSY is ignored; it is neither queued nor counted.
- DNA_VALUE and DNA_ERROR are updated only on entry to DONE. They never expose partial data.
- The mismatch flag and cap clear on entry to LOAD.
- RST at any cycle, including mid-pass: return to IDLE next edge and clear all outputs.
  - The primitive may be left partially shifted. This is harmless because every pass begins with LOAD.
  - If AUTO_START=1, a fresh read begins after RST is released.

## Timing
- Reset values: BUSY=0, DNA_VALID=0, DNA_ERROR=0, DNA_VALUE=0, DNA_READ=0, DNA_SHIFT=0.
- START accepted at edge t → DNA_READ=1 in cycle t+1, and BUSY=1 from cycle t+1.
- First SHIFT cycle is t+2.
- VERIFY=0: last capture cycle is t+1+DNA_WIDTH. DNA_VALID=1 and BUSY=0 from cycle t+2+DNA_WIDTH (97 cycles after the START edge for width 96).
- VERIFY=1: DNA_VALID=1 and BUSY=0 from cycle t+2+2·DNA_WIDTH (193 cycles for width 96).
- DNA_READ and DNA_SHIFT are never high in the same cycle.
- DNA_SHIFT is high for exactly DNA_WIDTH (or 2·DNA_WIDTH) consecutive cycles per read.
- DOUT is sampled in the same cycle SHIFT is high, with no extra register stage. The primitive's output is registered on CLK and meets single-cycle timing.

## Test plan
- SIM_DNA_VALUE=96'h0123_4567_89AB_CDEF_FEDC_BA98, VERIFY=1, AUTO_START=1, release RST → DNA_VALID rises 193 cycles later, DNA_VALUE equals the SIM value, DNA_ERROR=0, READ pulses once, SHIFT is high for 192 cycles.
- Same value, VERIFY=0, pulse START from IDLE → DNA_VALID exactly 97 cycles after the START edge; the DNA_DOUT trace over cycles t+2..t+97 equals SIM bits 0..95.
- Behavioural model injecting a flipped DOUT at verify index 40 → DNA_VALUE equals the true value, DNA_ERROR=1.
- Pulse START at capture index 50, and again during VERIFY → ignored; completion timing is unchanged and there is a single READ pulse.
- Assert RST at capture index 30, release, then pulse START → all outputs are 0 during and after RST, the new read completes with the correct value, and no stale DNA_VALID appears.
- From DONE, pulse START twice back-to-back with value 96'hFFFF…FFFD → DNA_VALID drops the cycle after the first pulse, the second pulse is ignored, and the final DNA_VALUE is 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFD.
